// File: rtl/trng_bit_collector.sv
// Collects the raw TRNG bit stream: synchronise, decimate, pack MSB-first into words,
// and block output once a repetition-count health test trips.
module trng_bit_collector #(
  parameter int WORD_W    = 32,
  parameter int DECIM     = 4,
  parameter int RCT_LIMIT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              random_bit,
  input  logic              word_ready,
  input  logic              clear_fail,
  output logic [WORD_W-1:0] word_data,
  output logic              word_valid,
  output logic              health_fail,
  output logic [15:0]       drop_cnt
);

  localparam int DW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int BW = $clog2(WORD_W);
  localparam int RW = $clog2(RCT_LIMIT + 1);
  localparam logic [DW-1:0] DLAST = DW'(DECIM - 1);
  localparam logic [BW-1:0] BLAST = BW'(WORD_W - 1);
  localparam logic [RW-1:0] RLIM  = RW'(RCT_LIMIT);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_FAIL} state_e;

  state_e            state_q, state_d;
  logic              s1_q, sb_q;
  logic [DW-1:0]     dcnt_q, dcnt_d;
  logic [BW-1:0]     bcnt_q, bcnt_d;
  logic [RW-1:0]     run_q, run_d;
  logic              last_q, last_d;
  logic [WORD_W-1:0] sr_q, sr_d;
  logic [WORD_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              hf_q, hf_d;
  logic [15:0]       drop_q, drop_d;

  logic              active, strobe, trip, complete, failing;
  logic [RW-1:0]     run_nx;
  logic [WORD_W-1:0] word_nx;

  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    bcnt_d  = bcnt_q;
    run_d   = run_q;
    last_d  = last_q;
    sr_d    = sr_q;
    data_d  = data_q;
    valid_d = valid_q;
    hf_d    = hf_q;
    drop_d  = drop_q;

    // Sampling stops the same cycle enable drops, so no stray bit enters the word.
    active   = (state_q == S_COLLECT && enable) || state_q == S_FAIL;
    strobe   = active && (dcnt_q == DLAST);
    if (run_q == '0 || sb_q != last_q) run_nx = RW'(1);
    else if (run_q == RLIM)            run_nx = RLIM;
    else                               run_nx = run_q + RW'(1);
    trip     = strobe && state_q == S_COLLECT && run_nx == RLIM;
    complete = strobe && bcnt_q == BLAST;
    failing  = state_q == S_FAIL || trip;
    word_nx  = {sr_q[WORD_W-2:0], sb_q};

    if (active) dcnt_d = strobe ? '0 : dcnt_q + DW'(1);
    if (strobe) begin
      sr_d   = word_nx;
      last_d = sb_q;
      run_d  = run_nx;
      bcnt_d = complete ? '0 : bcnt_q + BW'(1);
    end

    if (valid_q && word_ready) valid_d = 1'b0;
    if (complete && !failing) begin
      if (!valid_q || word_ready) begin
        data_d  = word_nx;
        valid_d = 1'b1;
      end else if (drop_q != 16'hFFFF) begin
        drop_d = drop_q + 16'd1;
      end
    end
    if (trip) hf_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        dcnt_d = '0;
        bcnt_d = '0;
        run_d  = '0;
        if (enable) state_d = S_COLLECT;
      end
      S_COLLECT: begin
        if (!enable)   state_d = S_IDLE;
        else if (trip) state_d = S_FAIL;
      end
      S_FAIL: begin
        if (clear_fail) begin
          hf_d    = 1'b0;
          run_d   = '0;
          bcnt_d  = '0;
          dcnt_d  = '0;
          state_d = enable ? S_COLLECT : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      s1_q    <= 1'b0;
      sb_q    <= 1'b0;
      dcnt_q  <= '0;
      bcnt_q  <= '0;
      run_q   <= '0;
      last_q  <= 1'b0;
      sr_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      hf_q    <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      s1_q    <= random_bit;
      sb_q    <= s1_q;
      dcnt_q  <= dcnt_d;
      bcnt_q  <= bcnt_d;
      run_q   <= run_d;
      last_q  <= last_d;
      sr_q    <= sr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      hf_q    <= hf_d;
      drop_q  <= drop_d;
    end
  end

  assign word_data   = data_q;
  assign word_valid  = valid_q;
  assign health_fail = hf_q;
  assign drop_cnt    = drop_q;

endmodule

// File: tb/tb_trng_bit_collector.sv
// Directed bench for trng_bit_collector: a DECIM=1 and a DECIM=4 instance share stimulus.
module tb_trng_bit_collector;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0, random_bit = 1'b0, word_ready = 1'b0, clear_fail = 1'b0;
  logic [7:0]  d1, d4;
  logic        v1, v4, hf1, hf4;
  logic [15:0] dc1, dc4;

  int n_cmp = 0, n_err = 0, cyc = 0;
  logic [7:0] q1[$];
  int         t4[$];

  trng_bit_collector #(.WORD_W(8), .DECIM(1), .RCT_LIMIT(16)) dut1 (
    .clk(clk), .rst(rst), .enable(enable), .random_bit(random_bit),
    .word_ready(word_ready), .clear_fail(clear_fail), .word_data(d1),
    .word_valid(v1), .health_fail(hf1), .drop_cnt(dc1));

  trng_bit_collector #(.WORD_W(8), .DECIM(4), .RCT_LIMIT(16)) dut4 (
    .clk(clk), .rst(rst), .enable(enable), .random_bit(random_bit),
    .word_ready(word_ready), .clear_fail(clear_fail), .word_data(d4),
    .word_valid(v4), .health_fail(hf4), .drop_cnt(dc4));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Transfer monitor, sampled mid-cycle.
  always @(negedge clk) if (!rst) begin
    if (v1 && word_ready) q1.push_back(d1);
    if (v4 && word_ready) t4.push_back(cyc);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; enable = 1'b0; clear_fail = 1'b0; random_bit = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    q1.delete(); t4.delete();
  endtask

  // Feed n bits MSB-first; enable rises one cycle after the first bit so that
  // the first strobe lands on bits[n-1] through the 2-FF synchroniser.
  task automatic feed(input logic [63:0] bits, input int n, input bit stop);
    for (int i = 0; i < n + 2; i++) begin
      if (i < n) random_bit = bits[n-1-i];
      if (i == 1) enable = 1'b1;
      tick();
    end
    if (stop) enable = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    do_reset();
    chk("rst_data",  d1, 0);
    chk("rst_valid", v1, 0);
    chk("rst_hf",    hf1, 0);
    chk("rst_drop",  dc1, 0);

    // 1: single word 8'hB2
    word_ready = 1'b1;
    feed(64'hB2, 8, 1);
    chk("t1_count", q1.size(), 1);
    if (q1.size() > 0) chk("t1_data", q1[0], 8'hB2);

    // 2: back-pressure, 24 alternating samples
    do_reset();
    word_ready = 1'b0;
    feed(64'hAAAAAA, 24, 1);
    chk("t2_valid", v1, 1);
    chk("t2_data",  d1, 8'hAA);
    chk("t2_drop",  dc1, 2);
    chk("t2_none",  q1.size(), 0);
    word_ready = 1'b1;
    repeat (4) tick();
    chk("t2_count", q1.size(), 1);
    if (q1.size() > 0) chk("t2_xdata", q1[0], 8'hAA);
    chk("t2_vfall", v1, 0);

    // 3: stuck-at-1 source trips the health test
    do_reset();
    word_ready = 1'b1;
    feed(64'hFFFF, 16, 1);
    chk("t3_count", q1.size(), 1);
    if (q1.size() > 0) chk("t3_data", q1[0], 8'hFF);
    chk("t3_hf",    hf1, 1);
    chk("t3_drop",  dc1, 0);
    chk("t3_valid", v1, 0);
    q1.delete();
    clear_fail = 1'b1; tick(); clear_fail = 1'b0; tick();
    chk("t3_hfclr", hf1, 0);
    feed(64'hAA, 8, 1);
    chk("t3_resume", q1.size(), 1);
    if (q1.size() > 0) chk("t3_rdata", q1[0], 8'hAA);

    // 4: partial word discarded by enable low
    do_reset();
    word_ready = 1'b1;
    feed(64'h1F, 5, 1);
    chk("t4_partial", q1.size(), 0);
    feed(64'h69, 8, 1);
    chk("t4_count", q1.size(), 1);
    if (q1.size() > 0) chk("t4_data", q1[0], 8'h69);

    // 5: asynchronous reset with a pending word and drops
    do_reset();
    word_ready = 1'b0;
    feed(64'hAAAAAAAA, 32, 1);
    chk("t5_drop",  dc1, 3);
    chk("t5_valid", v1, 1);
    #2 rst = 1'b1;
    #1;
    chk("t5_rdata",  d1, 0);
    chk("t5_rvalid", v1, 0);
    chk("t5_rhf",    hf1, 0);
    chk("t5_rdrop",  dc1, 0);
    tick();

    // 6: DECIM=4 word cadence
    do_reset();
    word_ready = 1'b1;
    enable = 1'b1;
    for (int k = 0; k < 200; k++) begin
      if (k % 4 == 0) random_bit = ~random_bit;
      tick();
    end
    enable = 1'b0;
    chk("t6_enough", (t4.size() >= 4) ? 1 : 0, 1);
    for (int i = 1; i < 4; i++)
      if (i < t4.size()) chk($sformatf("t6_gap%0d", i), t4[i] - t4[i-1], 32);
    chk("t6_hf", hf4, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
